// File: rtl/syn_decay_bank.sv
// -----------------------------------------------------------------------------
// syn_decay_bank
// Time-multiplexed synaptic-current decay unit for the Izhikevich neuron
// pipeline. Each channel holds a current i_st and a pending-input accumulator.
// A step pulse starts a sweep over all channels, one channel per valid/ready
// handshake, computing
//     i_prime = -((i_st * decay) >>> FRAC)
//     i       = sat(i_st + i_prime + pending)
// and committing i back into i_st when the consumer accepts the result.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (aborts a sweep)
//   write      accumulate curr_in into pending[wr_ch] this cycle
//   wr_ch      target channel of write (values >= N_CH are ignored)
//   curr_in    signed input current, Q1.(WIDTH-1)
//   decay      unsigned decay coefficient, decay/2^FRAC, sampled on step
//   step       start-of-timestep pulse, begins a sweep from IDLE
//   busy       high while sweeping
//   out_valid  result for out_ch is presented
//   out_ready  downstream accepts the result
//   out_ch     channel being presented
//   i_prime    decay term of out_ch
//   i          updated current of out_ch
//   done       one-cycle pulse after the last channel commits
// -----------------------------------------------------------------------------
module syn_decay_bank #(
    parameter int WIDTH = 17,
    parameter int FRAC  = 16,
    parameter int N_CH  = 4,
    parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    write,
    input  logic [CH_W-1:0]         wr_ch,
    input  logic signed [WIDTH-1:0] curr_in,
    input  logic [WIDTH-1:0]        decay,
    input  logic                    step,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_W-1:0]         out_ch,
    output logic signed [WIDTH-1:0] i_prime,
    output logic signed [WIDTH-1:0] i,
    output logic                    done
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CH_W-1:0]         ptr_q, ptr_d;
    logic [WIDTH-1:0]        decay_q, decay_d;
    logic                    done_q, done_d;
    logic signed [WIDTH-1:0] i_st_q [N_CH];
    logic signed [WIDTH-1:0] i_st_d [N_CH];
    logic signed [WIDTH-1:0] pend_q [N_CH];
    logic signed [WIDTH-1:0] pend_d [N_CH];

    logic                    hs_s;
    logic signed [WIDTH-1:0] cur_i_s;
    logic signed [WIDTH-1:0] cur_p_s;
    logic signed [2*WIDTH-1:0] prod_s;
    logic signed [WIDTH-1:0] ip_s;
    logic signed [WIDTH+1:0] sum_s;
    logic signed [WIDTH-1:0] i_s;

    // Clamp a WIDTH+2 bit signed value into the WIDTH bit signed range.
    function automatic logic signed [WIDTH-1:0] sat_clamp(input logic signed [WIDTH+1:0] v);
        logic signed [WIDTH+1:0] max_v;
        logic signed [WIDTH+1:0] min_v;
        max_v = {3'b000, {(WIDTH-1){1'b1}}};
        min_v = {3'b111, {(WIDTH-1){1'b0}}};
        if (v > max_v) begin
            return max_v[WIDTH-1:0];
        end else if (v < min_v) begin
            return min_v[WIDTH-1:0];
        end else begin
            return v[WIDTH-1:0];
        end
    endfunction

    assign busy      = (state_q == ST_SWEEP);
    assign out_valid = (state_q == ST_SWEEP);
    assign out_ch    = ptr_q;
    assign done      = done_q;
    assign i_prime   = ip_s;
    assign i         = i_s;

    // Select the channel under the pointer; a compare loop keeps the
    // selection legal when CH_W is wider than the channel count needs.
    always_comb begin
        cur_i_s = '0;
        cur_p_s = '0;
        for (int k = 0; k < N_CH; k++) begin
            cur_i_s = (ptr_q == CH_W'(k)) ? i_st_q[k] : cur_i_s;
            cur_p_s = (ptr_q == CH_W'(k)) ? pend_q[k] : cur_p_s;
        end
    end

    // Decay datapath: full-width product with decay zero-extended so a
    // coefficient with its top bit set is still treated as positive.
    always_comb begin
        prod_s = (2*WIDTH)'(cur_i_s) * $signed({{WIDTH{1'b0}}, decay_q});
        ip_s   = WIDTH'(-(prod_s >>> FRAC));
        sum_s  = (WIDTH+2)'(cur_i_s) + (WIDTH+2)'(ip_s) + (WIDTH+2)'(cur_p_s);
        i_s    = sat_clamp(sum_s);
    end

    // FSM next state, pointer, decay capture and done pulse.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        decay_d = decay_q;
        done_d  = 1'b0;
        hs_s    = (state_q == ST_SWEEP) && out_ready;
        case (state_q)
            ST_IDLE: begin
                if (step) begin
                    state_d = ST_SWEEP;
                    ptr_d   = '0;
                    decay_d = decay;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (out_ready) begin
                    if (ptr_q == CH_W'(N_CH - 1)) begin
                        state_d = ST_IDLE;
                        ptr_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_q + CH_W'(1);
                    end
                end else begin
                    ptr_d = ptr_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // Per-channel state update. A write landing on the committing channel
    // starts the next timestep's accumulator instead of joining this one.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            i_st_d[k] = i_st_q[k];
            pend_d[k] = pend_q[k];
            if (hs_s && (ptr_q == CH_W'(k))) begin
                i_st_d[k] = i_s;
                pend_d[k] = (write && (wr_ch == CH_W'(k))) ? curr_in : '0;
            end else if (write && (wr_ch == CH_W'(k))) begin
                pend_d[k] = sat_clamp((WIDTH+2)'(pend_q[k]) + (WIDTH+2)'(curr_in));
            end else begin
                pend_d[k] = pend_q[k];
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            decay_q <= '0;
            done_q  <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                i_st_q[k] <= '0;
                pend_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            decay_q <= decay_d;
            done_q  <= done_d;
            for (int k = 0; k < N_CH; k++) begin
                i_st_q[k] <= i_st_d[k];
                pend_q[k] <= pend_d[k];
            end
        end
    end

endmodule

// File: tb/tb_syn_decay_bank.sv
// -----------------------------------------------------------------------------
// Testbench for syn_decay_bank. A reference model predicts every channel's
// result when a sweep is launched and pushes it to a scoreboard queue; a
// monitor pops and compares on each handshake and checks the done pulse.
// -----------------------------------------------------------------------------
module tb_syn_decay_bank;

    localparam int WIDTH = 17;
    localparam int FRAC  = 16;
    localparam int N_CH  = 4;
    localparam int CH_W  = 3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    write;
    logic [CH_W-1:0]         wr_ch;
    logic signed [WIDTH-1:0] curr_in;
    logic [WIDTH-1:0]        decay;
    logic                    step;
    logic                    busy;
    logic                    out_valid;
    logic                    out_ready;
    logic [CH_W-1:0]         out_ch;
    logic signed [WIDTH-1:0] i_prime;
    logic signed [WIDTH-1:0] i;
    logic                    done;

    syn_decay_bank #(
        .WIDTH(WIDTH), .FRAC(FRAC), .N_CH(N_CH), .CH_W(CH_W)
    ) dut (
        .clk(clk), .rst(rst), .write(write), .wr_ch(wr_ch), .curr_in(curr_in),
        .decay(decay), .step(step), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_ch(out_ch), .i_prime(i_prime), .i(i),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     ch;
        longint ip;
        longint iv;
    } exp_t;

    exp_t   sb[$];
    longint i_m [N_CH];
    longint p_m [N_CH];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     hs_cnt   = 0;
    int     done_cnt = 0;
    logic   last_hs  = 1'b0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > 64'sd65535) return 64'sd65535;
        if (v < -64'sd65536) return -64'sd65536;
        return v;
    endfunction

    function automatic longint wrap(input longint v);
        longint m;
        m = v & 64'sh1FFFF;
        if (m >= 64'sd65536) m = m - 64'sd131072;
        return m;
    endfunction

    task automatic model_write(input int ch, input longint c);
        if (ch < N_CH) p_m[ch] = sat(p_m[ch] + c);
    endtask

    task automatic model_step(input longint d);
        exp_t e;
        longint prod;
        for (int k = 0; k < N_CH; k++) begin
            prod = i_m[k] * d;
            e.ch = k;
            e.ip = wrap(-(prod >>> FRAC));
            e.iv = sat(i_m[k] + e.ip + p_m[k]);
            sb.push_back(e);
            i_m[k] = e.iv;
            p_m[k] = 0;
        end
    endtask

    task automatic model_clear();
        sb.delete();
        for (int k = 0; k < N_CH; k++) begin
            i_m[k] = 0;
            p_m[k] = 0;
        end
    endtask

    // Monitor: compare on every handshake, check done follows the last commit.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_hs = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (done || last_hs) check_eq("done_after_last", done, last_hs);
                last_hs = out_valid && out_ready && (out_ch == CH_W'(N_CH - 1));
                if (out_valid && out_ready) begin
                    hs_cnt++;
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_result: got ch %0d, expected no result", out_ch);
                    end else begin
                        e = sb.pop_front();
                        check_eq("out_ch", out_ch, e.ch);
                        check_eq("i_prime", i_prime, e.ip);
                        check_eq("i", i, e.iv);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog expired");
    end

    task automatic do_write(input int ch, input longint c);
        write   = 1'b1;
        wr_ch   = CH_W'(ch);
        curr_in = c[WIDTH-1:0];
        @(posedge clk); #1;
        write = 1'b0;
        model_write(ch, c);
    endtask

    task automatic launch(input longint d);
        step  = 1'b1;
        decay = d[WIDTH-1:0];
        model_step(d);
        @(posedge clk); #1;
        step = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("sweep_timeout", (n < 40) ? 1 : 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_sweep(input longint d);
        int n;
        int d0;
        d0 = done_cnt;
        launch(d);
        wait_idle(n);
        check_eq("sweep_cycles", n, N_CH);
        check_eq("done_pulses", done_cnt - d0, 1);
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_valid"}, out_valid, 0);
        check_eq({tag, "_out_ch"}, out_ch, 0);
        check_eq({tag, "_i"}, i, 0);
        check_eq({tag, "_i_prime"}, i_prime, 0);
    endtask

    initial begin
        int n;
        int h0;
        int d0;
        logic signed [WIDTH-1:0] hold_i;

        rst = 1'b1; write = 1'b0; wr_ch = '0; curr_in = '0;
        decay = '0; step = 1'b0; out_ready = 1'b1;
        model_clear();
        repeat (2) @(posedge clk); #1;
        check_idle_zero("reset");
        check_eq("reset_done", done, 0);
        rst = 1'b0;

        // Decay chain on ch0: 32768 -> 32704 -> 32641 at decay 128.
        do_write(0, 32768);
        repeat (3) run_sweep(128);

        // Negative current on ch2.
        do_write(2, -32768);
        repeat (2) run_sweep(128);

        // Saturation of pending and of the updated current on ch1.
        do_write(1, 65535);
        do_write(1, 65535);
        run_sweep(0);
        do_write(1, 100);
        run_sweep(0);

        // Stall at ch1 for three cycles, then write ch1 in the commit cycle.
        d0 = done_cnt;
        launch(128);
        @(posedge clk); #1;
        check_eq("stall_at_ch1", out_ch, 1);
        out_ready = 1'b0;
        hold_i = i;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_eq("stall_out_ch", out_ch, 1);
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_i_hold", i, hold_i);
        end
        out_ready = 1'b1;
        write = 1'b1; wr_ch = CH_W'(1); curr_in = 17'sd10;
        @(posedge clk); #1;
        write = 1'b0;
        model_write(1, 10);
        wait_idle(n);
        check_eq("stall_done_pulses", done_cnt - d0, 1);
        run_sweep(128);

        // Step while sweeping is ignored.
        h0 = hs_cnt;
        d0 = done_cnt;
        launch(128);
        step = 1'b1; decay = 17'd999;
        @(posedge clk); #1;
        step = 1'b0;
        wait_idle(n);
        check_eq("ignored_step_handshakes", hs_cnt - h0, N_CH);
        check_eq("ignored_step_done", done_cnt - d0, 1);

        // Out-of-range channel write is dropped.
        do_write(5, 1234);
        run_sweep(128);

        // Randomised writes and decay values.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < N_CH; k++) begin
                do_write(k, longint'($urandom_range(65535)) - 64'sd32768);
            end
            run_sweep(longint'($urandom_range(131071)));
        end

        // Reset mid-sweep at ptr 2.
        do_write(3, 5000);
        launch(128);
        n = 0;
        while (out_ch != CH_W'(2) && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("reached_ptr2", out_ch, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle_zero("mid_reset");
        rst = 1'b0;
        model_clear();
        run_sweep(128);

        check_eq("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/syn_decay_bank.md
Name: syn_decay_bank

Overview:
- Parametrised, time-multiplexed synaptic-current decay unit for the Izhikevich neuron pipeline; generalises the two-channel decay block to N_CH channels.
- Holds per-channel current state i and a per-channel pending-input accumulator.
- On each timestep pulse it sweeps all channels, one per handshake, applying i' = -(i*decay) and i_next = sat(i + i' + pending).
- It streams each channel's results to the neuron update stage over a valid/ready interface.

Parameters:
- WIDTH, 17: signed two's-complement width of currents, Q1.(WIDTH-1).
- FRAC, 16: fractional bits of the decay coefficient and of currents.
- N_CH, 4: number of channels.
- CH_W, max(1, clog2(N_CH)): channel index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- write  in  1  add curr_in into pending[wr_ch] this cycle
- wr_ch  in  CH_W  target channel of write
- curr_in  in  WIDTH  signed input current to accumulate
- decay  in  WIDTH  unsigned decay coefficient, value decay/2^FRAC; sampled when step is accepted
- step  in  1  start-of-timestep pulse; begins a sweep
- busy  out  1  high in SWEEP state
- out_valid  out  1  result for out_ch is presented
- out_ready  in  1  downstream accepts result
- out_ch  out  CH_W  channel being presented
- i_prime  out  WIDTH  decay term for out_ch
- i  out  WIDTH  updated current for out_ch
- done  out  1  one-cycle pulse after the last channel commits

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high.
- Reset state: state=IDLE, ptr=0, all i_st[] and pending[] = 0, decay_q=0. Outputs: busy=0, out_valid=0, out_ch=0, done=0. i and i_prime show channel 0 values (0).
- rst mid-sweep aborts the sweep. rst has priority over write and step in the same cycle.
- FSM IDLE:
  - step=1: decay_q <= decay, ptr <= 0, go to SWEEP. The first result is valid the next cycle (1-cycle latency).
  - step is ignored while in SWEEP.
- FSM SWEEP:
  - out_valid=1, out_ch=ptr.
  - i and i_prime are combinational from i_st[ptr], pending[ptr] and decay_q.
  - Handshake = out_valid & out_ready. On handshake: i_st[ptr] <= i and the channel commits.
  - ptr == N_CH-1 on handshake: go to IDLE, ptr <= 0, done=1 for exactly the next cycle.
  - Otherwise ptr <= ptr+1. This gives one channel per cycle with out_ready held high, so a sweep takes N_CH cycles.
  - out_ready=0: hold ptr, no commit, no state change.
- Arithmetic:
  - prod = i_st[ptr] (signed) × zero-extended decay_q, full 2*WIDTH width.
  - i_prime = -(prod >>> FRAC), arithmetic shift (floor), truncated to WIDTH.
  - i = sat(i_st + i_prime + pending), summed at WIDTH+2 bits and clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Writes:
  - Accepted in any state: pending[wr_ch] <= sat(pending[wr_ch] + curr_in).
  - wr_ch >= N_CH is ignored.
  - Write to ptr in a commit cycle: pending[ptr] <= curr_in, so the input lands in the next timestep.
  - Commit with no write to ptr: pending[ptr] <= 0.
- Stall: while stalled, a write to ptr updates pending[ptr], so i may change under valid. The consumer must use only the value present at the handshake.
- Non-swept channels keep their state. decay changing mid-sweep has no effect.

Test Plan:
- Decay chain: rst, write ch0 curr_in=32768 (0.5), step with decay=128, ready=1.
  - Sweep1: ch0 i=32768, i_prime=0.
  - Sweep2: i_prime=-64, i=32704.
  - Sweep3: i_prime=-63, i=32641.
  - Each sweep gives out_ch 0..3 on consecutive cycles, then done pulses once.
- Negative and saturation:
  - ch2 write -32768, two sweeps at decay=128: i=-32768, then i_prime=+64, i=-32704.
  - ch1 write 65535 twice, then sweep at decay=0: pending saturates, ch1 i=65535.
  - Add 100, sweep again: i stays 65535.
- Stall: out_ready=0 for 3 cycles at ch1.
  - out_ch stays 1, valid stays high, no commit.
  - Write ch1 curr_in=10 in the commit cycle: ch1 excludes the 10 this sweep and includes +10 next sweep.
- Control robustness:
  - step during SWEEP is ignored; the sweep takes exactly N_CH handshakes and one done pulse.
  - write with wr_ch=5 at N_CH=4 (CH_W=3) leaves all states unchanged.
- Reset mid-sweep: assert rst at ptr=2.
  - Next cycle busy=0, out_valid=0, all currents 0.
  - Subsequent step sweeps i=0 on all channels.
